// File: rtl/seq_pattern_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seq_pattern_ctrl: programmable table-driven pattern count sequencer    |
// | Optional descending playback (dir_i) enabled by SEQ_CTRL_DIR_EN.        |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module seq_pattern_ctrl #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int LW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SEQ_CTRL_DIR_EN
    input  logic             dir_i,
`endif
    input  logic             cfg_we_i,
    input  logic [AW-1:0]    cfg_addr_i,
    input  logic [WIDTH-1:0] cfg_data_i,
    input  logic [AW-1:0]    cfg_last_i,
    input  logic [LW-1:0]    loops_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             stop_i,
    output logic [WIDTH-1:0] count_o,
    output logic             count_vld_o,
    output logic             wrap_o,
    output logic             done_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    pass_q, pass_d;
    logic [AW-1:0]    last_q, last_d;
    logic [LW-1:0]    loops_q, loops_d;
    logic             fin_q, fin_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             vld_q, vld_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] table_q [DEPTH];

    logic             w_idle;
    logic             w_busy;
    logic             w_we;
    logic             w_dir;
    logic [AW-1:0]    w_last;
    logic [LW-1:0]    w_loops;
    logic [LW-1:0]    w_pass;
    logic [AW-1:0]    w_first;
    logic [AW-1:0]    w_entry;
    logic             w_at_end;
    logic             w_adv;

    function automatic logic [WIDTH-1:0] f_default(input int i);
        case (i)
            1:       return WIDTH'(2);
            2:       return WIDTH'(5);
            3:       return WIDTH'(7);
            default: return '0;
        endcase
    endfunction

    assign w_idle = (state_q == S_IDLE);
    assign w_busy = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign w_we   = cfg_we_i && !w_busy;

`ifdef SEQ_CTRL_DIR_EN
    logic dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (w_idle && start_i && !stop_i) begin
            dir_q <= dir_i;
        end
    end

    assign w_dir = w_idle ? dir_i : dir_q;
`else
    assign w_dir = 1'b0;
`endif

    // In IDLE the run parameters are taken straight from the inputs so the
    // start edge can already present the first entry.
    assign w_last   = w_idle ? cfg_last_i : last_q;
    assign w_loops  = w_idle ? loops_i    : loops_q;
    assign w_pass   = w_idle ? '0         : pass_q;
    assign w_first  = w_dir  ? w_last     : '0;
    assign w_entry  = w_idle ? w_first    : idx_q;
    assign w_at_end = w_dir  ? (w_entry == '0) : (w_entry == w_last);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        last_d  = last_q;
        loops_d = loops_q;
        fin_d   = fin_q;
        count_d = count_q;
        vld_d   = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        w_adv   = 1'b0;

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (start_i && !stop_i) begin
                    state_d = S_RUN;
                    last_d  = cfg_last_i;
                    loops_d = loops_i;
                    pass_d  = '0;
                    fin_d   = 1'b0;
                    w_adv   = 1'b1;
                end
            end
            S_RUN, S_PAUSE: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    fin_d   = 1'b0;
                end else if (pause_i) begin
                    state_d = S_PAUSE;
                end else if (fin_q) begin
                    // Final entry was already presented; close the run.
                    state_d = S_DONE;
                    count_d = '0;
                    done_d  = 1'b1;
                    fin_d   = 1'b0;
                end else begin
                    state_d = S_RUN;
                    w_adv   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                count_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        if (w_adv) begin
            count_d = table_q[w_entry];
            vld_d   = 1'b1;
            wrap_d  = w_at_end;
            if (w_at_end) begin
                idx_d = w_first;
                if ((w_loops != '0) && (w_pass == w_loops - LW'(1))) begin
                    fin_d = 1'b1;
                end else if ((w_loops != '0) || !(&w_pass)) begin
                    pass_d = w_pass + LW'(1);
                end
            end else begin
                idx_d = w_dir ? (w_entry - AW'(1)) : (w_entry + AW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pass_q  <= '0;
            last_q  <= '0;
            loops_q <= '0;
            fin_q   <= 1'b0;
            count_q <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            last_q  <= last_d;
            loops_q <= loops_d;
            fin_q   <= fin_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= f_default(i);
            end
        end else if (w_we) begin
            table_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    assign count_o     = count_q;
    assign count_vld_o = vld_q;
    assign wrap_o      = wrap_q;
    assign done_o      = done_q;
    assign busy_o      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_seq_pattern_ctrl: directed self-checking bench for seq_pattern_ctrl |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_seq_pattern_ctrl;

    logic       clk;
    logic       rst_n;
    logic       dir;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [2:0] cfg_data;
    logic [1:0] cfg_last;
    logic [7:0] loops;
    logic       start;
    logic       pause;
    logic       stop;
    logic [2:0] count;
    logic       count_vld;
    logic       wrap;
    logic       done;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    seq_pattern_ctrl #(.WIDTH(3), .DEPTH(4), .AW(2), .LW(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef SEQ_CTRL_DIR_EN
        .dir_i       (dir),
`endif
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_data_i  (cfg_data),
        .cfg_last_i  (cfg_last),
        .loops_i     (loops),
        .start_i     (start),
        .pause_i     (pause),
        .stop_i      (stop),
        .count_o     (count),
        .count_vld_o (count_vld),
        .wrap_o      (wrap),
        .done_o      (done),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {count, count_vld, wrap, done, busy}.
    task automatic chk_out(input string tag, input int cnt, input bit vld,
                           input bit wr, input bit dn, input bit bsy);
        logic [2:0] c;
        c = cnt[2:0];
        chk(tag, {25'd0, count, count_vld, wrap, done, busy},
                 {25'd0, c, vld, wr, dn, bsy});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] last, input logic [7:0] nl);
        cfg_last = last;
        loops    = nl;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int seq_a[4];
        int seq_b[6];
        seq_a = '{0, 2, 5, 7};
        seq_b = '{1, 3, 4, 1, 3, 4};

        rst_n = 1'b0; dir = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        cfg_last = '0; loops = '0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        #3;
        chk_out("reset", 0, 0, 0, 0, 0);
        #9 rst_n = 1'b1;
        tick();
        chk_out("idle_after_reset", 0, 0, 0, 0, 0);

        // One-shot single pass of the default table.
        do_start(2'd3, 8'd1);
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("t1_play%0d", i), seq_a[i], 1, (i == 3), 0, 1);
            if (i < 3) tick();
        end
        tick();
        chk_out("t1_done", 0, 0, 0, 1, 0);
        tick();
        chk_out("t1_idle", 0, 0, 0, 0, 0);

        // Continuous mode, stopped after ten values.
        do_start(2'd3, 8'd0);
        for (int i = 0; i < 10; i++) begin
            chk_out($sformatf("t2_play%0d", i), seq_a[i % 4], 1, ((i % 4) == 3), 0, 1);
            if (i < 9) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t2_stop_idle", 0, 0, 0, 0, 0);
        tick();
        chk_out("t2_no_done", 0, 0, 0, 0, 0);

        // Reprogrammed table, two passes over three entries.
        cfg_we = 1'b1;
        cfg_addr = 2'd0; cfg_data = 3'd1; tick();
        cfg_addr = 2'd1; cfg_data = 3'd3; tick();
        cfg_addr = 2'd2; cfg_data = 3'd4; tick();
        cfg_we = 1'b0;
        do_start(2'd2, 8'd2);
        for (int i = 0; i < 6; i++) begin
            chk_out($sformatf("t3_play%0d", i), seq_b[i], 1, ((i % 3) == 2), 0, 1);
            if (i < 5) tick();
        end
        tick();
        chk_out("t3_done", 0, 0, 0, 1, 0);
        tick();

        // Asynchronous reset mid-run, then default table replays.
        do_start(2'd3, 8'd0);
        chk_out("t6_pre0", 1, 1, 0, 0, 1);
        tick();
        chk_out("t6_pre1", 3, 1, 0, 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk_out("t6_async_reset", 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        tick();
        chk_out("t6_idle", 0, 0, 0, 0, 0);
        do_start(2'd3, 8'd1);
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("t6_play%0d", i), seq_a[i], 1, (i == 3), 0, 1);
            if (i < 3) tick();
        end
        tick();
        chk_out("t6_done", 0, 0, 0, 1, 0);
        tick();

        // Pause for three cycles while 5 is shown.
        do_start(2'd3, 8'd0);
        tick();
        tick();
        chk_out("t4_at5", 5, 1, 0, 0, 1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t4_hold%0d", i), 5, 0, 0, 0, 1);
        end
        pause = 1'b0;
        tick();
        chk_out("t4_resume7", 7, 1, 1, 0, 1);
        tick();
        chk_out("t4_resume0", 0, 1, 0, 0, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("t4_stop", 0, 0, 0, 0, 0);

        // Write and start while busy are both dropped.
        do_start(2'd3, 8'd2);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 3'd6; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        chk_out("t5_play1", 2, 1, 0, 0, 1);
        tick();
        tick();
        chk_out("t5_wrap", 7, 1, 1, 0, 1);
        tick();
        chk_out("t5_pass2_first", 0, 1, 0, 0, 1);
        tick(); tick(); tick();
        chk_out("t5_pass2_last", 7, 1, 1, 0, 1);
        tick();
        chk_out("t5_done", 0, 0, 0, 1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("t5_start_in_done_ignored", 0, 0, 0, 0, 0);

        // start together with stop in IDLE stays idle.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_out("idle_start_stop", 0, 0, 0, 0, 0);

        // Single entry, write in the start cycle: old value first, new value after.
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 3'd3;
        do_start(2'd0, 8'd3);
        cfg_we = 1'b0;
        chk_out("single_old", 0, 1, 1, 0, 1);
        tick();
        chk_out("single_new1", 3, 1, 1, 0, 1);
        tick();
        chk_out("single_new2", 3, 1, 1, 0, 1);
        tick();
        chk_out("single_done", 0, 0, 0, 1, 0);
        tick();

`ifdef SEQ_CTRL_DIR_EN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        dir = 1'b1;
        do_start(2'd3, 8'd1);
        dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("dir_play%0d", i), seq_a[3 - i], 1, (i == 3), 0, 1);
            if (i < 3) tick();
        end
        tick();
        chk_out("dir_done", 0, 0, 0, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
